// File: rtl/instruction_fetch_unit.sv
// Fetch initiator: PC/wait counter into a 2-entry {PC,instr} prefetch queue; first word RD_WAIT+1 cycles after reset/redirect.
// Full queue parks fetch in HOLD with Address stable; IFETCH_XCHECK_EN halts on X/Z fetch data and raises Fault.

module instruction_fetch_unit #(
  parameter int RD_WAIT = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [63:0] StartPC,
  output logic [63:0] Address,
  input  logic [31:0] Data,
  output logic [31:0] InstrOut,
  output logic [63:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [63:0] RedirectPC,
  output logic        Fault
);

  typedef enum logic [1:0] {WAIT, HOLD, HALT} state_t;

  localparam logic [3:0]  RELOAD = 4'(RD_WAIT);
  localparam logic [63:0] ALIGN  = ~64'd3;

  state_t      state;
  logic [63:0] pc;
  logic [3:0]  cnt;

  logic [31:0] q_ins [2];
  logic [63:0] q_pc  [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;

  logic [31:0] out_ins;
  logic [63:0] out_pc;

  logic        pop;
  logic        space;
  logic        at_capture;
  logic        data_bad;
  logic        push;
  logic        halt_now;
  logic [31:0] nxt_ins;
  logic [63:0] nxt_pc;

`ifdef IFETCH_XCHECK_EN
  logic        fault_q;
`endif

  assign Address    = pc;
  assign InstrOut   = out_ins;
  assign InstrPC    = out_pc;
  assign InstrValid = (count != 2'd0);

`ifdef IFETCH_XCHECK_EN
  assign Fault = fault_q;
`else
  assign Fault = 1'b0;
`endif

  // Space is judged after this cycle's pop, so a full queue can push and pop together.
  always_comb begin
    pop        = (count != 2'd0) && InstrReady;
    space      = (count != 2'd2) || pop;
    at_capture = ((state == WAIT) && (cnt == 4'd0)) || (state == HOLD);
`ifdef IFETCH_XCHECK_EN
    data_bad   = $isunknown(Data);
`else
    data_bad   = 1'b0;
`endif
    push       = at_capture && space && !data_bad;
    halt_now   = at_capture && space && data_bad;
  end

  // Head output registers are loaded with whatever becomes the head after this edge.
  always_comb begin
    nxt_ins = out_ins;
    nxt_pc  = out_pc;
    if (pop) begin
      if (count == 2'd2) begin
        nxt_ins = q_ins[~head];
        nxt_pc  = q_pc[~head];
      end else if (push) begin
        nxt_ins = Data;
        nxt_pc  = pc;
      end
    end else if ((count == 2'd0) && push) begin
      nxt_ins = Data;
      nxt_pc  = pc;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc      <= StartPC & ALIGN;
      cnt     <= RELOAD;
      state   <= WAIT;
      head    <= 1'b0;
      tail    <= 1'b0;
      count   <= 2'd0;
      out_ins <= 32'd0;
      out_pc  <= 64'd0;
`ifdef IFETCH_XCHECK_EN
      fault_q <= 1'b0;
`endif
    end else if (Redirect) begin
      // Flush wins over any capture or pop in the same cycle.
      pc      <= RedirectPC & ALIGN;
      cnt     <= RELOAD;
      state   <= WAIT;
      head    <= 1'b0;
      tail    <= 1'b0;
      count   <= 2'd0;
`ifdef IFETCH_XCHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      count   <= count + 2'(push) - 2'(pop);
      head    <= head ^ pop;
      tail    <= tail ^ push;
      out_ins <= nxt_ins;
      out_pc  <= nxt_pc;
      if (push) begin
        q_ins[tail] <= Data;
        q_pc[tail]  <= pc;
        pc          <= pc + 64'd4;
        cnt         <= RELOAD;
        state       <= WAIT;
      end else if (halt_now) begin
        state   <= HALT;
`ifdef IFETCH_XCHECK_EN
        fault_q <= 1'b1;
`endif
      end else if (state == WAIT) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          state <= HOLD;
        end
      end
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch-side initiator for the read-only instruction memory. It holds the program counter, drives the memory `Address` bus, waits a fixed number of cycles for `Data` to settle, and captures each word with its PC into a 2-entry prefetch queue. The queue is drained by the decode stage over a valid/ready handshake. Branch and jump targets arrive on a redirect port, which flushes the queue and restarts fetch.

## Interface
- `RD_WAIT`, default 2: cycles to wait after `Address` changes before sampling `Data`. Range 0–15.
- `CLK` input 1: clock; all state updates on the rising edge.
- `Reset` input 1: synchronous, active-high reset.
- `StartPC` input 64: PC value loaded on reset.
- `Address` output 64: instruction memory address; equals the PC register.
- `Data` input 32: instruction word returned by memory.
- `InstrOut` output 32: instruction at the queue head.
- `InstrPC` output 64: PC of the queue-head instruction.
- `InstrValid` output 1: queue is non-empty.
- `InstrReady` input 1: decode accepts the head entry; a pop happens when `InstrValid && InstrReady`.
- `Redirect` input 1: one-cycle request to restart fetch.
- `RedirectPC` input 64: redirect target. Bits [1:0] are forced to 0.
- `Fault` output 1: fetch halted because of an X word. Tied to 0 when the Configuration feature is compiled out.

## Operation
- Registers:
  - `PC` (64 bits)
  - wait counter `cnt` (4 bits)
  - 2-entry queue of {PC, instr}, with head/tail pointers and a 2-bit count
  - state: WAIT, HOLD, HALT
- Reset:
  - `PC`=`{StartPC[63:2],2'b00}`, `cnt`=`RD_WAIT`
  - queue empty, state=WAIT, `Fault`=0
  - Outputs: `Address`=`StartPC` aligned, `InstrValid`=0, `InstrOut`=0, `InstrPC`=0.
- WAIT:
  - If `cnt`>0: decrement `cnt`.
  - If `cnt`==0 and the queue has space after this cycle's pop: push {`PC`,`Data`}, set `PC`=`PC`+4, reload `cnt`=`RD_WAIT`, stay in WAIT.
  - If `cnt`==0 and the queue is full with no pop this cycle: go to HOLD.
- HOLD:
  - `Address` stays stable.
  - On the first cycle with space (including a same-cycle pop), push `Data`, set `PC`+=4, reload `cnt`, go to WAIT.
- HALT: entered only under the Configuration feature. No capture; `Address` frozen.
- Redirect (highest priority, from any state):
  - Queue flushed; an in-flight capture that same cycle is discarded.
  - A pop that same cycle has no effect beyond the flush.
  - `PC`=`{RedirectPC[63:2],2'b00}`, `cnt`=`RD_WAIT`, state=WAIT, `Fault` cleared.
- Arithmetic: `PC`+4 is modulo 2^64, so 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
- Queue: strict FIFO order. Simultaneous push and pop when full is legal; the count is unchanged.
- Reset mid-operation overrides Redirect and all in-flight state.

## Timing
- Let E0 be the last edge with `Reset`=1.
- First capture happens at edge E0+`RD_WAIT`+1. `InstrValid` rises after that edge.
- No bypass: a push into an empty queue is visible on the next cycle.
- Steady state: one instruction per `RD_WAIT`+1 cycles.
- With `RD_WAIT`=0: one instruction per cycle.
- After a Redirect at edge Er:
  - `InstrValid`=0 and `Address`=target after Er.
  - First new capture at Er+`RD_WAIT`+1.
- `InstrOut`, `InstrPC` and `InstrValid` are registered, with no combinational path from `InstrReady`.
- `Address` is driven directly from the `PC` register.

## Configuration
- `IFETCH_XCHECK_EN` defined:
  - At capture time, if `Data` contains any X or Z bit (unmapped address), do not push, set `Fault`=1, and go to HALT.
  - Already-queued entries still drain.
  - HALT is left only by Redirect or Reset.
- `IFETCH_XCHECK_EN` undefined:
  - `Data` is captured unconditionally, with X propagated.
  - `Fault` is held at 0 and the HALT state is unreachable.

## Test plan
- Basic fetch: `StartPC`=0, `RD_WAIT`=2, `InstrReady`=1. Expect:
  - after E3: `InstrOut`=F84003E9, `InstrPC`=0
  - after E6: F84083EA / 0x4
  - after E9: F84103EB / 0x8
- Backpressure: `InstrReady`=0 from reset. Expect:
  - queue holds the 0x0 and 0x4 entries; `Address` sticks at 0x008 in HOLD
  - raising `InstrReady` pops F84003E9, then F84083EA, then F84103EB in order, with nothing lost or duplicated.
- Redirect mid-wait: pulse `Redirect` with `RedirectPC`=0x028 while `cnt`=1 and 1 entry is queued. Expect:
  - `InstrValid`=0 next cycle, `Address`=0x028
  - 3 cycles later `InstrOut`=17FFFFFD, `InstrPC`=0x028.
- Redirect coincident with capture at 0x014, target 0x032. Expect:
  - AA0B014A never appears
  - `Address`=0x030, next output is F84203ED / 0x030.
- PC wrap: `StartPC`=0xFFFF_FFFF_FFFF_FFFC. After the first capture, expect `Address`=0x0, and the next capture returns F84003E9 with `InstrPC`=0.
- `IFETCH_XCHECK_EN`: fetch runs into 0x058 (unmapped). Expect:
  - `Fault`=1, no push, `Address` frozen at 0x058
  - Redirect to 0x000 clears `Fault` and resumes with F84003E9.
  - Without the macro, the X word is queued and `Fault` stays 0.
